// File: rtl/mem_interface_pkg.sv
// Shared memory request/response types plus arbiter owner IDs.
// Used by mem_port_arbiter and its ID FIFO.
package mem_interface_pkg;

  localparam int MEM_ARB_MAX_OUTSTANDING_DEFAULT = 4;

  typedef enum logic {
    ARB_I = 1'b0,
    ARB_D = 1'b1
  } arb_id_e;

  typedef struct packed {
    logic        valid;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } mem_req_t;

  typedef struct packed {
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;
  } mem_resp_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between IF/MEM requesters, the arbiter and memory.
// slave = arbiter side, master = surrounding pipeline/memory side.
interface mem_port_arbiter_if;
  import mem_interface_pkg::*;

  mem_req_t  i_req_i;
  mem_resp_t i_resp_o;
  mem_req_t  d_req_i;
  mem_resp_t d_resp_o;
  mem_req_t  m_req_o;
  mem_resp_t m_resp_i;

  modport slave (
    input  i_req_i, d_req_i, m_resp_i,
    output i_resp_o, d_resp_o, m_req_o
  );

  modport master (
    output i_req_i, d_req_i, m_resp_i,
    input  i_resp_o, d_resp_o, m_req_o
  );
endinterface

// File: rtl/arb_id_fifo.sv
// In-order owner-ID FIFO for mem_port_arbiter.
// Power-of-two depth, so pointers simply wrap.
module arb_id_fifo
  import mem_interface_pkg::*;
#(
  parameter  int DEPTH = MEM_ARB_MAX_OUTSTANDING_DEFAULT,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  arb_id_e       din_i,
  input  logic          pop_i,
  output arb_id_e       head_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);
  arb_id_e       r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [CW-1:0] r_cnt;
  logic          w_push;
  logic          w_pop;

  assign full_o  = (r_cnt == CW'(DEPTH));
  assign empty_o = (r_cnt == '0);
  assign w_push  = push_i && !full_o;
  assign w_pop   = pop_i && !empty_o;
  assign head_o  = r_mem[r_rp];
  assign count_o = r_cnt;

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wp] <= din_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop)  r_rp <= r_rp + AW'(1);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// I/D memory port arbiter with in-order response steering.
// MEM_ARB_ROUND_ROBIN_EN selects round-robin, else fixed D priority.
module mem_port_arbiter
  import mem_interface_pkg::*;
#(
  parameter  int MAX_OUTSTANDING = MEM_ARB_MAX_OUTSTANDING_DEFAULT,
  localparam int CW = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  mem_port_arbiter_if.slave bus,
  output logic [CW-1:0]     pending_o,
  output logic              err_o
);
  logic      w_iv, w_dv, w_gv, w_hv;
  logic      w_full, w_empty, w_accept;
  logic      w_rv, w_pop;
  arb_id_e   w_pick, w_grant, w_head;
  arb_id_e   r_hold_id;
  logic      r_hold, r_err;
  mem_req_t  w_mreq;
  mem_resp_t w_iresp, w_dresp;

  assign w_iv = bus.i_req_i.valid && !rst_i;
  assign w_dv = bus.d_req_i.valid && !rst_i;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  arb_id_e r_last;

  always_comb begin
    w_pick = ARB_D;
    if (w_iv && w_dv)
      w_pick = (r_last == ARB_D) ? ARB_I : ARB_D;
    else if (w_iv)
      w_pick = ARB_I;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)         r_last <= ARB_I;
    else if (w_accept) r_last <= w_grant;
  end
`else
  assign w_pick = (w_iv && !w_dv) ? ARB_I : ARB_D;
`endif

  // A stalled grant stays put while its requester keeps valid.
  assign w_hv     = (r_hold_id == ARB_I) ? w_iv : w_dv;
  assign w_grant  = (r_hold && w_hv) ? r_hold_id : w_pick;
  assign w_gv     = (w_grant == ARB_I) ? w_iv : w_dv;
  assign w_accept = w_gv && bus.m_resp_i.ready && !w_full;
  assign w_rv     = bus.m_resp_i.rvalid && !rst_i;
  assign w_pop    = w_rv && !w_empty;

  arb_id_fifo #(.DEPTH(MAX_OUTSTANDING)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_accept),
    .din_i   (w_grant),
    .pop_i   (w_pop),
    .head_o  (w_head),
    .count_o (pending_o),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_hold    <= 1'b0;
      r_hold_id <= ARB_D;
      r_err     <= 1'b0;
    end else begin
      r_hold    <= w_gv && !w_accept;
      r_hold_id <= w_grant;
      if (w_rv && w_empty) r_err <= 1'b1;
    end
  end

  always_comb begin
    w_mreq = (w_grant == ARB_I) ? bus.i_req_i
                                : bus.d_req_i;
    w_mreq.valid = w_gv && !w_full;
    w_iresp = '0;
    w_dresp = '0;
    w_iresp.ready = w_accept && (w_grant == ARB_I);
    w_dresp.ready = w_accept && (w_grant == ARB_D);
    unique case (1'b1)
      w_pop && (w_head == ARB_I): begin
        w_iresp.rvalid = 1'b1;
        w_iresp.rdata  = bus.m_resp_i.rdata;
      end
      w_pop && (w_head == ARB_D): begin
        w_dresp.rvalid = 1'b1;
        w_dresp.rdata  = bus.m_resp_i.rdata;
      end
      default: ;
    endcase
  end

  assign bus.m_req_o  = w_mreq;
  assign bus.i_resp_o = w_iresp;
  assign bus.d_resp_o = w_dresp;
  assign err_o        = r_err;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (MAX_OUTSTANDING=4).
// Grant expectations follow MEM_ARB_ROUND_ROBIN_EN.
module tb_mem_port_arbiter;
  import mem_interface_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] pend;
  logic       err;
  int         total = 0;
  int         bad = 0;

  mem_port_arbiter_if bus();

  mem_port_arbiter dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .bus       (bus),
    .pending_o (pend),
    .err_o     (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv, dv, mrdy, rv;
    logic [31:0] daddr, rdata;
    logic        e_irdy, e_drdy, e_mv;
    logic [31:0] e_maddr;
    logic        e_irv, e_drv;
    logic [31:0] e_ird, e_drd;
    logic [2:0]  e_pend;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(
    logic iv, logic dv, logic mrdy, logic rv,
    logic [31:0] daddr, logic [31:0] rdata,
    logic e_irdy, logic e_drdy, logic e_mv,
    logic [31:0] e_maddr, logic e_irv, logic e_drv,
    logic [31:0] e_ird, logic [31:0] e_drd,
    logic [2:0] e_pend);
    vec_t v;
    v.iv = iv; v.dv = dv; v.mrdy = mrdy; v.rv = rv;
    v.daddr = daddr; v.rdata = rdata;
    v.e_irdy = e_irdy; v.e_drdy = e_drdy;
    v.e_mv = e_mv; v.e_maddr = e_maddr;
    v.e_irv = e_irv; v.e_drv = e_drv;
    v.e_ird = e_ird; v.e_drd = e_drd;
    v.e_pend = e_pend;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic dv,
                       input logic mrdy, input logic rv,
                       input logic [31:0] daddr,
                       input logic [31:0] rdata);
    bus.i_req_i = '0;
    bus.i_req_i.valid = iv;
    bus.i_req_i.addr  = 32'h1000;
    bus.i_req_i.be    = 4'hf;
    bus.d_req_i = '0;
    bus.d_req_i.valid = dv;
    bus.d_req_i.addr  = daddr;
    bus.d_req_i.be    = 4'hf;
    bus.m_resp_i = '0;
    bus.m_resp_i.ready  = mrdy;
    bus.m_resp_i.rvalid = rv;
    bus.m_resp_i.rdata  = rdata;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".mv"}, 32'(bus.m_req_o.valid), 0);
    chk({tag, ".irdy"}, 32'(bus.i_resp_o.ready), 0);
    chk({tag, ".drdy"}, 32'(bus.d_resp_o.ready), 0);
    chk({tag, ".irv"}, 32'(bus.i_resp_o.rvalid), 0);
    chk({tag, ".drv"}, 32'(bus.d_resp_o.rvalid), 0);
    chk({tag, ".ird"}, bus.i_resp_o.rdata, 0);
    chk({tag, ".drd"}, bus.d_resp_o.rdata, 0);
  endtask

  initial begin
    logic gd, prev_gd;
    string s;

    // single-D reads, responses two cycles later
    tv.push_back(mk(0,1,1,0,'h100,0,   0,1,1,'h100,0,0,0,0,   0));
    tv.push_back(mk(0,1,1,0,'h104,0,   0,1,1,'h104,0,0,0,0,   1));
    tv.push_back(mk(0,1,1,1,'h108,'hA, 0,1,1,'h108,0,1,0,'hA, 2));
    tv.push_back(mk(0,0,1,1,0,'hB,     0,0,0,0,0,1,0,'hB,     2));
    tv.push_back(mk(0,0,1,1,0,'hC,     0,0,0,0,0,1,0,'hC,     1));
    tv.push_back(mk(0,0,1,0,0,0,       0,0,0,0,0,0,0,0,       0));
    // interleaved I, D, I ownership
    tv.push_back(mk(1,0,1,0,0,0,       1,0,1,'h1000,0,0,0,0,  0));
    tv.push_back(mk(0,1,1,0,'h200,0,   0,1,1,'h200,0,0,0,0,   1));
    tv.push_back(mk(1,0,1,0,0,0,       1,0,1,'h1000,0,0,0,0,  2));
    tv.push_back(mk(0,0,1,1,0,'h11,    0,0,0,0,1,0,'h11,0,    3));
    tv.push_back(mk(0,0,1,1,0,'h22,    0,0,0,0,0,1,0,'h22,    2));
    tv.push_back(mk(0,0,1,1,0,'h33,    0,0,0,0,1,0,'h33,0,    1));
    tv.push_back(mk(0,0,1,0,0,0,       0,0,0,0,0,0,0,0,       0));
    // memory not ready, then fill to MAX_OUTSTANDING
    tv.push_back(mk(0,1,0,0,'h300,0,   0,0,1,'h300,0,0,0,0,   0));
    tv.push_back(mk(0,1,1,0,'h300,0,   0,1,1,'h300,0,0,0,0,   0));
    tv.push_back(mk(0,1,1,0,'h304,0,   0,1,1,'h304,0,0,0,0,   1));
    tv.push_back(mk(0,1,1,0,'h308,0,   0,1,1,'h308,0,0,0,0,   2));
    tv.push_back(mk(0,1,1,0,'h30C,0,   0,1,1,'h30C,0,0,0,0,   3));
    tv.push_back(mk(0,1,1,0,'h310,0,   0,0,0,0,0,0,0,0,       4));
    tv.push_back(mk(0,1,1,1,'h310,'h55,0,0,0,0,0,1,0,'h55,    4));
    tv.push_back(mk(0,1,1,0,'h310,0,   0,1,1,'h310,0,0,0,0,   3));
    tv.push_back(mk(0,0,1,1,0,'h66,    0,0,0,0,0,1,0,'h66,    4));
    tv.push_back(mk(0,0,1,1,0,'h77,    0,0,0,0,0,1,0,'h77,    3));
    tv.push_back(mk(0,0,1,1,0,'h88,    0,0,0,0,0,1,0,'h88,    2));
    tv.push_back(mk(0,0,1,1,0,'h99,    0,0,0,0,0,1,0,'h99,    1));
    tv.push_back(mk(0,0,1,0,0,0,       0,0,0,0,0,0,0,0,       0));

    // reset with active inputs
    rst = 1'b1;
    drive(1, 1, 1, 1, 'h100, 'h5A);
    tick();
    tick();
    chk_quiet("rst");
    chk("rst.pend", 32'(pend), 0);
    chk("rst.err", 32'(err), 0);
    rst = 1'b0;
    drive(0, 0, 1, 0, 0, 0);
    #1;
    chk_quiet("post_rst");
    chk("post_rst.pend", 32'(pend), 0);

    foreach (tv[k]) begin
      drive(tv[k].iv, tv[k].dv, tv[k].mrdy, tv[k].rv,
            tv[k].daddr, tv[k].rdata);
      #2;
      s = $sformatf("v%0d", k);
      chk({s, ".irdy"}, 32'(bus.i_resp_o.ready), 32'(tv[k].e_irdy));
      chk({s, ".drdy"}, 32'(bus.d_resp_o.ready), 32'(tv[k].e_drdy));
      chk({s, ".mv"}, 32'(bus.m_req_o.valid), 32'(tv[k].e_mv));
      if (tv[k].e_mv)
        chk({s, ".maddr"}, bus.m_req_o.addr, tv[k].e_maddr);
      chk({s, ".irv"}, 32'(bus.i_resp_o.rvalid), 32'(tv[k].e_irv));
      chk({s, ".drv"}, 32'(bus.d_resp_o.rvalid), 32'(tv[k].e_drv));
      chk({s, ".ird"}, bus.i_resp_o.rdata, tv[k].e_ird);
      chk({s, ".drd"}, bus.d_resp_o.rdata, tv[k].e_drd);
      chk({s, ".pend"}, 32'(pend), 32'(tv[k].e_pend));
      chk({s, ".err"}, 32'(err), 0);
      tick();
    end

    // both requesters valid for 8 cycles from a fresh reset
    rst = 1'b1;
    drive(0, 0, 1, 0, 0, 0);
    tick();
    rst = 1'b0;
    prev_gd = 1'b0;
    for (int k = 0; k < 9; k++) begin
      drive(k < 8, k < 8, 1, k > 0, 'h2000, 32'(k));
      #2;
      s = $sformatf("arb%0d", k);
`ifdef MEM_ARB_ROUND_ROBIN_EN
      gd = (k % 2 == 0);
`else
      gd = 1'b1;
`endif
      if (k < 8) begin
        chk({s, ".maddr"}, bus.m_req_o.addr, gd ? 32'h2000 : 32'h1000);
        chk({s, ".drdy"}, 32'(bus.d_resp_o.ready), 32'(gd));
        chk({s, ".irdy"}, 32'(bus.i_resp_o.ready), 32'(!gd));
        chk({s, ".pend"}, 32'(pend), (k == 0) ? 0 : 1);
      end
      if (k > 0) begin
        chk({s, ".drv"}, 32'(bus.d_resp_o.rvalid), 32'(prev_gd));
        chk({s, ".irv"}, 32'(bus.i_resp_o.rvalid), 32'(!prev_gd));
      end
      prev_gd = gd;
      tick();
    end
    drive(0, 0, 1, 0, 0, 0);
    #1;
    chk("arb.drained", 32'(pend), 0);

    // orphan response
    drive(0, 0, 1, 1, 0, 'h99);
    #1;
    chk("orph.irv", 32'(bus.i_resp_o.rvalid), 0);
    chk("orph.drv", 32'(bus.d_resp_o.rvalid), 0);
    chk("orph.err_before", 32'(err), 0);
    tick();
    drive(0, 0, 1, 0, 0, 0);
    #1;
    chk("orph.err", 32'(err), 1);
    chk("orph.pend", 32'(pend), 0);
    tick();
    tick();
    chk("orph.err_sticky", 32'(err), 1);

    // reset with two transactions outstanding
    drive(0, 1, 1, 0, 'h400, 0);
    tick();
    tick();
    chk("mid.pend2", 32'(pend), 2);
    rst = 1'b1;
    drive(1, 1, 1, 1, 'h404, 'h77);
    #1;
    chk_quiet("mid_rst");
    tick();
    rst = 1'b0;
    drive(0, 0, 1, 0, 0, 0);
    #1;
    chk("mid.pend0", 32'(pend), 0);
    chk("mid.err0", 32'(err), 0);
    chk_quiet("mid_after");
    drive(0, 0, 1, 1, 0, 'h88);
    #1;
    chk("mid.orph_drv", 32'(bus.d_resp_o.rvalid), 0);
    chk("mid.orph_drd", bus.d_resp_o.rdata, 0);
    tick();
    drive(0, 0, 1, 0, 0, 0);
    #1;
    chk("mid.orph_err", 32'(err), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter sharing a single memory port between the instruction-fetch path and the data path of the pipelined core. It grants one `mem_req_t` per cycle to the memory, records which requester owns each accepted transaction in an in-order ID FIFO, and steers each returning `mem_resp_t` back to its owner. It sits between the IF/MEM stages and the unified memory interface.

## Interface
- `MAX_OUTSTANDING`, 4: max accepted-but-unanswered transactions; power of two, 2..16.
- `clk_i` in 1: single clock, all state on rising edge.
- `rst_i` in 1: synchronous, active-high reset.
- `i_req_i` in `mem_req_t`: instruction-fetch request.
- `i_resp_o` out `mem_resp_t`: instruction-fetch response.
- `d_req_i` in `mem_req_t`: data request from MEM stage.
- `d_resp_o` out `mem_resp_t`: data response to MEM stage.
- `m_req_o` out `mem_req_t`: request to memory.
- `m_resp_i` in `mem_resp_t`: memory response.
- `pending_o` out `$clog2(MAX_OUTSTANDING+1)`: current outstanding count.
- `err_o` out 1: sticky; set on orphan response.

## Operation
- Request accepted when the granted requester has `valid`, `m_resp_i.ready`=1 and the ID FIFO is not full; on acceptance the owner ID (`ARB_I`/`ARB_D`) is pushed.
- `m_req_o` = granted request with `valid` forced 0 when FIFO full or no requester valid.
- Requester `ready`: 1 only for the granted requester, and only when `m_resp_i.ready`=1 and FIFO not full; the non-granted requester sees `ready`=0.
- Every accepted transaction (read or write) returns exactly one `m_resp_i.rvalid`, in order.
- On `m_resp_i.rvalid`: pop FIFO head; owner's `rvalid`=1 with `rdata` passed through; other requester's `rvalid`=0, `rdata`=0.
- `rvalid` with FIFO empty: response dropped, `err_o` set and held until reset.
- Full FIFO blocks acceptance even if a pop occurs the same cycle (no full-bypass); push+pop together when not full leaves count unchanged.
- Request held while `ready`=0 must remain stable; the arbiter may change grant only after an accepted transfer or when the granted requester drops `valid`.
- `pending_o` = FIFO occupancy; never exceeds `MAX_OUTSTANDING`.

## Timing
- Request path combinational: zero added cycles; acceptance and FIFO push in the same cycle.
- Response steering combinational from FIFO head; zero added latency.
- Throughput: one acceptance per cycle; back-to-back responses supported.
- Reset (while `rst_i`=1 and the cycle after release settles): `m_req_o.valid`=0, both `ready`=0, both `rvalid`=0, `rdata`=0, FIFO empty, `pending_o`=0, `err_o`=0, RR pointer favors D.
- Reset mid-transaction: outstanding IDs discarded; later orphan responses set `err_o`.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined: round-robin; last-granted pointer flips only on an accepted transfer; after reset D wins first tie.
- Not defined: fixed priority, D always wins over I when both valid; no pointer register.

## Structure
- `mem_interface_pkg`: add `arb_id_e` enum {`ARB_I`, `ARB_D`} and `MEM_ARB_MAX_OUTSTANDING_DEFAULT`=4.
- Sub-module `arb_id_fifo`: synchronous FIFO of `arb_id_e`, depth `MAX_OUTSTANDING`, wrap-around pointers, count output, full/empty flags.
- Grant logic and response steering stay in the top module.

## Test plan
- Only D valid, ready=1, 3 reads to 0x100/0x104/0x108, memory answers 2 cycles later with 0xA/0xB/0xC -> `d_resp_o.rvalid` 3 times with those values in order, `i_resp_o.rvalid` never 1, `pending_o` peaks at 2.
- I and D both valid every cycle for 8 cycles, RR enabled -> grants alternate D,I,D,I...; RR disabled -> 8 D grants, I starved.
- 4 accepted with no responses (MAX_OUTSTANDING=4) -> both `ready`=0, `m_req_o.valid`=0; first response frees one slot next cycle.
- Interleaved I,D,I accepted, responses 0x11/0x22/0x33 -> I gets 0x11, D gets 0x22, I gets 0x33.
- `rvalid` with `pending_o`=0 -> response dropped, `err_o`=1 until `rst_i`.
- `rst_i` with 2 outstanding -> `pending_o`=0 next cycle, all outputs at reset values.
